// File: rtl/sdram_pkg.sv
// Shared constants, init FSM states and command decode helper for the SDRAM command sequencer.
// Used by sdram_cmd_sequencer and sdram_refresh_timer (SDRAM_REF_DEBT_EN selects refresh debt mode).
package sdram_pkg;

  localparam logic [2:0] CMD_NOP       = 3'b000;
  localparam logic [2:0] CMD_READA     = 3'b001;
  localparam logic [2:0] CMD_WRITEA    = 3'b010;
  localparam logic [2:0] CMD_PRECHARGE = 3'b011;

  localparam int unsigned DEF_ASIZE        = 23;
  localparam int unsigned DEF_REF_PER      = 1024;
  localparam int unsigned DEF_INIT_PER     = 24000;
  localparam int unsigned DEF_INIT_GAP     = 20;
  localparam int unsigned DEF_INIT_REF_CNT = 8;
  localparam int unsigned DEF_DEBT_MAX     = 4;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_PRE,
    ST_REF,
    ST_LMR,
    ST_DONE
  } init_state_t;

  typedef struct packed {
    logic nop;
    logic reada;
    logic writea;
    logic precharge;
  } cmd_dec_t;

  // One-hot decode of the host command; reserved codes decode to all-low.
  function automatic cmd_dec_t decode_cmd(input logic [2:0] cmd);
    cmd_dec_t d;
    d = '0;
    case (cmd)
      CMD_NOP:       d.nop       = 1'b1;
      CMD_READA:     d.reada     = 1'b1;
      CMD_WRITEA:    d.writea    = 1'b1;
      CMD_PRECHARGE: d.precharge = 1'b1;
      default:       d           = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Periodic refresh timer with postponed-refresh debt tracking.
// SDRAM_REF_DEBT_EN defined: debt counts up to DEBT_MAX; undefined: single sticky request.
module sdram_refresh_timer
  import sdram_pkg::*;
#(
  parameter int unsigned REF_PER  = DEF_REF_PER,
  parameter int unsigned DEBT_MAX = DEF_DEBT_MAX
) (
  input  logic CLK,
  input  logic RESET,
  input  logic init_done,
  input  logic ref_ack,
  output logic ref_req,
  output logic ref_urgent
);

`ifdef SDRAM_REF_DEBT_EN
  localparam int unsigned DMAX = DEBT_MAX;
`else
  localparam int unsigned DMAX = 1;
`endif
  localparam int unsigned TMR_W  = $clog2(REF_PER);
  localparam int unsigned DEBT_W = $clog2(DMAX + 1);
  localparam logic [TMR_W-1:0]  RELOAD   = TMR_W'(REF_PER - 1);
  localparam logic [DEBT_W-1:0] DEBT_TOP = DEBT_W'(DMAX);

  logic              running, running_nxt;
  logic [TMR_W-1:0]  tmr, tmr_nxt;
  logic [DEBT_W-1:0] debt, debt_nxt;
  logic              inc, dec;

  // Timer stays idle until init completes, then free-runs.
  always_comb begin
    running_nxt = running;
    tmr_nxt     = tmr;
    debt_nxt    = debt;
    inc         = running && (tmr == '0);
    dec         = ref_ack && (debt != '0);
    if (!running) begin
      if (init_done) begin
        running_nxt = 1'b1;
        tmr_nxt     = RELOAD;
      end
    end else if (tmr == '0) begin
      tmr_nxt = RELOAD;
    end else begin
      tmr_nxt = tmr - TMR_W'(1);
    end
`ifndef SDRAM_REF_DEBT_EN
    if (running && ref_ack) tmr_nxt = RELOAD;
`endif
    // Coincident expiry and acknowledge cancel out.
    if (inc && !dec) begin
      if (debt != DEBT_TOP) debt_nxt = debt + DEBT_W'(1);
    end else if (dec && !inc) begin
      debt_nxt = debt - DEBT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      running    <= 1'b0;
      tmr        <= '0;
      debt       <= '0;
      ref_req    <= 1'b0;
      ref_urgent <= 1'b0;
    end else begin
      running    <= running_nxt;
      tmr        <= tmr_nxt;
      debt       <= debt_nxt;
      ref_req    <= (debt_nxt != '0);
      ref_urgent <= (debt_nxt == DEBT_TOP);
    end
  end

endmodule

// File: rtl/sdram_cmd_sequencer.sv
// SDRAM command sequencer: registered command decode, power-up init sequence, refresh scheduling.
// Build option SDRAM_REF_DEBT_EN enables multi-entry refresh debt in sdram_refresh_timer.
module sdram_cmd_sequencer
  import sdram_pkg::*;
#(
  parameter int unsigned ASIZE        = DEF_ASIZE,
  parameter int unsigned REF_PER      = DEF_REF_PER,
  parameter int unsigned INIT_PER     = DEF_INIT_PER,
  parameter int unsigned INIT_GAP     = DEF_INIT_GAP,
  parameter int unsigned INIT_REF_CNT = DEF_INIT_REF_CNT,
  parameter int unsigned DEBT_MAX     = DEF_DEBT_MAX
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [2:0]       CMD,
  input  logic [ASIZE-1:0] ADDR,
  input  logic             CM_ACK,
  input  logic             REF_ACK,
  output logic             NOP,
  output logic             READA,
  output logic             WRITEA,
  output logic             PRECHARGE,
  output logic [ASIZE-1:0] SADDR,
  output logic             IPRECHARGE,
  output logic             REFRESH,
  output logic             LOAD_MODE,
  output logic             INIT_REQ,
  output logic             INIT_DONE,
  output logic             REF_REQ,
  output logic             REF_URGENT,
  output logic             CMD_ACK
);

  localparam int unsigned CNT_MAX = (INIT_PER > INIT_GAP) ? INIT_PER : INIT_GAP;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned RC_W    = $clog2(INIT_REF_CNT + 1);
  localparam logic [CNT_W-1:0] WAIT_END = CNT_W'(INIT_PER);
  localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(INIT_GAP - 1);
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(INIT_REF_CNT - 1);

  init_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [RC_W-1:0]  rc, rc_nxt;
  logic             init_req_nxt, ipre_nxt, refresh_nxt, lmr_nxt, init_done_nxt;
  logic             gap_hit;
  cmd_dec_t         dec_nxt;

  assign gap_hit = (cnt == GAP_END);

  // Init sequence: power-up wait, then one pulse per INIT_GAP-clock slot.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    rc_nxt        = rc;
    init_req_nxt  = 1'b0;
    ipre_nxt      = 1'b0;
    refresh_nxt   = 1'b0;
    lmr_nxt       = 1'b0;
    init_done_nxt = INIT_DONE;
    case (state)
      ST_WAIT: begin
        if (cnt == WAIT_END) begin
          state_nxt = ST_PRE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt      = cnt + CNT_W'(1);
          init_req_nxt = 1'b1;
        end
      end
      ST_PRE: begin
        if (gap_hit) begin
          ipre_nxt  = 1'b1;
          state_nxt = ST_REF;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_REF: begin
        if (gap_hit) begin
          refresh_nxt = 1'b1;
          cnt_nxt     = '0;
          if (rc == RC_LAST) begin
            rc_nxt    = '0;
            state_nxt = ST_LMR;
          end else begin
            rc_nxt = rc + RC_W'(1);
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_LMR: begin
        if (gap_hit) begin
          lmr_nxt   = 1'b1;
          state_nxt = ST_DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_DONE: init_done_nxt = 1'b1;
      default: state_nxt = ST_WAIT;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= ST_WAIT;
      cnt        <= '0;
      rc         <= '0;
      INIT_REQ   <= 1'b0;
      IPRECHARGE <= 1'b0;
      REFRESH    <= 1'b0;
      LOAD_MODE  <= 1'b0;
      INIT_DONE  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      rc         <= rc_nxt;
      INIT_REQ   <= init_req_nxt;
      IPRECHARGE <= ipre_nxt;
      REFRESH    <= refresh_nxt;
      LOAD_MODE  <= lmr_nxt;
      INIT_DONE  <= init_done_nxt;
    end
  end

  // Host commands are masked to NOP until initialisation has finished.
  always_comb begin
    dec_nxt = decode_cmd(CMD);
    if (!INIT_DONE) dec_nxt = '{nop: 1'b1, reada: 1'b0, writea: 1'b0, precharge: 1'b0};
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      NOP       <= 1'b0;
      READA     <= 1'b0;
      WRITEA    <= 1'b0;
      PRECHARGE <= 1'b0;
      SADDR     <= '0;
      CMD_ACK   <= 1'b0;
    end else begin
      NOP       <= dec_nxt.nop;
      READA     <= dec_nxt.reada;
      WRITEA    <= dec_nxt.writea;
      PRECHARGE <= dec_nxt.precharge;
      SADDR     <= ADDR;
      CMD_ACK   <= CM_ACK & ~CMD_ACK;
    end
  end

  sdram_refresh_timer #(
    .REF_PER  (REF_PER),
    .DEBT_MAX (DEBT_MAX)
  ) u_refresh_timer (
    .CLK        (CLK),
    .RESET      (RESET),
    .init_done  (INIT_DONE),
    .ref_ack    (REF_ACK),
    .ref_req    (REF_REQ),
    .ref_urgent (REF_URGENT)
  );

endmodule

// File: tb/tb_sdram_cmd_sequencer.sv
// Directed bench for sdram_cmd_sequencer with small timing parameters.
// Refresh expectations follow whether SDRAM_REF_DEBT_EN is defined.
module tb_sdram_cmd_sequencer;

  localparam int unsigned ASIZE = 23;
`ifdef SDRAM_REF_DEBT_EN
  localparam bit DEBT_MODE = 1'b1;
  localparam int EXP1  = 109;
  localparam int COINC = 125;
`else
  localparam bit DEBT_MODE = 1'b0;
  localparam int EXP1  = 119;
  localparam int COINC = 135;
`endif

  logic             CLK = 1'b0;
  logic             RESET;
  logic [2:0]       CMD;
  logic [ASIZE-1:0] ADDR;
  logic             CM_ACK, REF_ACK;
  logic             NOP, READA, WRITEA, PRECHARGE;
  logic [ASIZE-1:0] SADDR;
  logic             IPRECHARGE, REFRESH, LOAD_MODE, INIT_REQ, INIT_DONE;
  logic             REF_REQ, REF_URGENT, CMD_ACK;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [2:0] cmd_v [5] = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b111};
  logic [3:0] dec_v [5] = '{4'b1000, 4'b0010, 4'b0001, 4'b0000, 4'b0000};

  sdram_cmd_sequencer #(
    .ASIZE(ASIZE), .REF_PER(16), .INIT_PER(10), .INIT_GAP(4),
    .INIT_REF_CNT(2), .DEBT_MAX(3)
  ) dut (
    .CLK(CLK), .RESET(RESET), .CMD(CMD), .ADDR(ADDR), .CM_ACK(CM_ACK), .REF_ACK(REF_ACK),
    .NOP(NOP), .READA(READA), .WRITEA(WRITEA), .PRECHARGE(PRECHARGE), .SADDR(SADDR),
    .IPRECHARGE(IPRECHARGE), .REFRESH(REFRESH), .LOAD_MODE(LOAD_MODE),
    .INIT_REQ(INIT_REQ), .INIT_DONE(INIT_DONE), .REF_REQ(REF_REQ),
    .REF_URGENT(REF_URGENT), .CMD_ACK(CMD_ACK)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic tick_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_reset_state();
    check("rst_outputs", {NOP, READA, WRITEA, PRECHARGE, IPRECHARGE, REFRESH, LOAD_MODE,
                          INIT_REQ, INIT_DONE, REF_REQ, REF_URGENT, CMD_ACK}, 64'd0);
    check("rst_saddr", SADDR, 64'd0);
  endtask

  // Cycle k counts clock edges since reset release; CMD is READA throughout.
  task automatic init_check(input int upto);
    for (int k = 1; k <= upto; k++) begin
      tick();
      check("init_req", INIT_REQ, 64'(k <= 10));
      check("init_pulses", {IPRECHARGE, REFRESH, LOAD_MODE},
            {k == 15, (k == 19) || (k == 23), k == 27});
      check("init_done", INIT_DONE, 64'(k >= 28));
      check("nop_forced", {NOP, READA, WRITEA, PRECHARGE}, 64'b1000);
    end
  endtask

  initial begin
    logic [ASIZE-1:0] a;
    RESET = 1'b0; CMD = 3'b001; ADDR = 23'h12345; CM_ACK = 1'b0; REF_ACK = 1'b0;
    #1 RESET = 1'b1;
    tick(); tick();
    check_reset_state();

    RESET = 1'b0; cyc = 0;
    init_check(28);

    ADDR = 23'h5A5A5;
    tick();
    check("reada_after_init", {NOP, READA, WRITEA, PRECHARGE}, 64'b0100);
    check("saddr_reada", SADDR, 64'h5A5A5);

    for (int i = 0; i < 5; i++) begin
      CMD = cmd_v[i];
      a = ASIZE'($urandom);
      ADDR = a;
      tick();
      check("decode", {NOP, READA, WRITEA, PRECHARGE}, 64'(dec_v[i]));
      check("saddr", SADDR, 64'(a));
    end
    CMD = 3'b000;

    CM_ACK = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("cmd_ack_alt", CMD_ACK, 64'(i % 2 == 0));
    end
    CM_ACK = 1'b0;
    tick();
    check("cmd_ack_idle", CMD_ACK, 64'd0);

    tick_to(44);
    check("ref_before_first", {REF_REQ, REF_URGENT}, 64'b00);
    tick();
    check("ref_first_expiry", {REF_REQ, REF_URGENT}, {1'b1, DEBT_MODE ? 1'b0 : 1'b1});
    tick_to(100);
    check("ref_saturated", {REF_REQ, REF_URGENT}, 64'b11);

    REF_ACK = 1'b1;
    tick();
    check("ref_ack1", {REF_REQ, REF_URGENT}, {DEBT_MODE ? 1'b1 : 1'b0, 1'b0});
    tick(); tick();
    REF_ACK = 1'b0;
    check("ref_ack3_clear", {REF_REQ, REF_URGENT}, 64'b00);

    tick_to(EXP1 - 1);
    check("ref_pre_next", REF_REQ, 64'd0);
    tick();
    check("ref_next_expiry", REF_REQ, 64'd1);

    tick_to(COINC - 1);
    check("ref_before_coinc", REF_REQ, 64'd1);
    REF_ACK = 1'b1;
    tick();
    REF_ACK = 1'b0;
    check("ref_coinc", {REF_REQ, REF_URGENT}, {1'b1, DEBT_MODE ? 1'b0 : 1'b1});
    tick();
    check("ref_after_coinc", REF_REQ, 64'd1);

    CMD = 3'b001;
    RESET = 1'b1;
    #1 check_reset_state();
    tick();
    check_reset_state();
    RESET = 1'b0; cyc = 0;
    init_check(17);
    #3 RESET = 1'b1;
    #1 check_reset_state();
    tick();
    check_reset_state();
    RESET = 1'b0; cyc = 0;
    init_check(28);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
